// File: rtl/meter_scheduler_if.sv
// Button, tick and status bundle between the meter front panel and meter_scheduler.
// Signal prefixes are from the scheduler's point of view.
interface meter_scheduler_if;
  logic        i_tick20;
  logic        i_tick1;
  logic [3:0]  i_add_btn;
  logic        i_rst10_btn;
  logic        i_rst205_btn;
  logic [13:0] o_time_remain;
  logic        o_expired;
  logic        o_holding;
  logic [5:0]  o_pending;
  logic [5:0]  o_grant;

  modport master (
    output i_tick20, i_tick1, i_add_btn, i_rst10_btn, i_rst205_btn,
    input  o_time_remain, o_expired, o_holding, o_pending, o_grant
  );

  modport slave (
    input  i_tick20, i_tick1, i_add_btn, i_rst10_btn, i_rst205_btn,
    output o_time_remain, o_expired, o_holding, o_pending, o_grant
  );
endinterface

// File: rtl/meter_scheduler.sv
// Remaining-time owner for the traffic meter: queues button presses, serves one per
// 20 Hz slot with fixed priority and merges them with the 1 Hz countdown.
module meter_scheduler (
  input logic               clk,
  input logic               reset,
  meter_scheduler_if.slave  io_bus
);
  typedef enum logic [1:0] {StEmpty, StRun, StHold10, StHold205} state_e;

  localparam logic [13:0] MaxTime = 14'd9999;

  state_e      r_state, w_state_next;
  logic [13:0] r_time, w_time_next;
  logic [5:0]  r_prev, r_pending, r_grant;
  logic [5:0]  w_pending_next, w_grant_next, w_btn, w_edge, w_sel;
  logic [13:0] w_add_val, w_sat;
  logic [14:0] w_sum;
  logic        w_in_hold;

  assign w_btn  = {io_bus.i_rst205_btn, io_bus.i_rst10_btn, io_bus.i_add_btn};
  assign w_edge = w_btn & ~r_prev;

  // rst10 > rst205 > add550 > add200 > add180 > add10
  always_comb begin
    w_sel = '0;
    if      (r_pending[4]) w_sel[4] = 1'b1;
    else if (r_pending[5]) w_sel[5] = 1'b1;
    else if (r_pending[3]) w_sel[3] = 1'b1;
    else if (r_pending[2]) w_sel[2] = 1'b1;
    else if (r_pending[1]) w_sel[1] = 1'b1;
    else if (r_pending[0]) w_sel[0] = 1'b1;
  end

  always_comb begin
    w_add_val = 14'd0;
    if      (w_sel[3]) w_add_val = 14'd550;
    else if (w_sel[2]) w_add_val = 14'd200;
    else if (w_sel[1]) w_add_val = 14'd180;
    else if (w_sel[0]) w_add_val = 14'd10;
  end

  assign w_sum = {1'b0, r_time} + {1'b0, w_add_val};
  assign w_sat = (w_sum > {1'b0, MaxTime}) ? MaxTime : w_sum[13:0];

  always_comb begin
    w_state_next   = r_state;
    w_time_next    = r_time;
    w_grant_next   = '0;
    w_pending_next = r_pending;
    w_in_hold      = (r_state == StHold10) || (r_state == StHold205);

    if (io_bus.i_tick20) begin
      if (!w_in_hold) w_grant_next = w_sel;
      // A press on a bit already queued is dropped, even if that bit is served now.
      w_pending_next = (r_pending & ~w_grant_next) | (w_edge & ~r_pending);
    end

    unique case (r_state)
      StEmpty, StRun: begin
        if (w_grant_next[4]) begin
          w_time_next  = 14'd10;
          w_state_next = StHold10;
        end else if (w_grant_next[5]) begin
          w_time_next  = 14'd205;
          w_state_next = StHold205;
        end else if (|w_grant_next[3:0]) begin
          if (r_state == StEmpty) w_time_next = w_add_val;
          else                    w_time_next = w_sat - {13'd0, io_bus.i_tick1};
          w_state_next = StRun;
        end else if ((r_state == StRun) && io_bus.i_tick1) begin
          w_time_next = r_time - 14'd1;
          if (r_time == 14'd1) w_state_next = StEmpty;
        end
      end
      StHold10: begin
        if (io_bus.i_tick20 && !w_btn[4]) w_state_next = StRun;
      end
      StHold205: begin
        if (io_bus.i_tick20 && !w_btn[5]) w_state_next = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StEmpty;
      r_time    <= 14'd0;
      r_prev    <= '0;
      r_pending <= '0;
      r_grant   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_time    <= w_time_next;
      r_pending <= w_pending_next;
      r_grant   <= w_grant_next;
      if (io_bus.i_tick20) r_prev <= w_btn;
    end
  end

  assign io_bus.o_time_remain = r_time;
  assign io_bus.o_expired     = (r_state == StEmpty);
  assign io_bus.o_holding     = (r_state == StHold10) || (r_state == StHold205);
  assign io_bus.o_pending     = r_pending;
  assign io_bus.o_grant       = r_grant;
endmodule

// File: doc/meter_scheduler.md
# meter_scheduler

Control block for the traffic meter's remaining-time register. It edge-detects the four coin-value buttons and two preset buttons, and queues each press as a pending request. It arbitrates the requests onto a single shared time-update path, one per 20 Hz slot, and merges them with the 1 Hz countdown. It owns the 14-bit remaining-time value that feeds the display/BCD stage, plus the expired/hold status for the indicator logic.

## Interface

- No parameters. Constants are fixed: max time 9999; add values 10/180/200/550; presets 10/205.
- `clk` in 1: single system clock. All state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `tick20` in 1: one-`clk`-wide 20 Hz enable. Buttons are sampled and requests served only on these cycles.
- `tick1` in 1: one-`clk`-wide 1 Hz enable (countdown).
- `add_btn` in 4: raw button levels. Bit 0 = +10, bit 1 = +180, bit 2 = +200, bit 3 = +550.
- `rst10_btn` in 1: preset-10 button level.
- `rst205_btn` in 1: preset-205 button level.
- `time_remain` out 14: remaining seconds, 0..9999.
- `expired` out 1: high while in EMPTY.
- `holding` out 1: high while in HOLD10 or HOLD205.
- `pending` out 6: pending requests. Bits [3:0] = add_btn, [4] = rst10, [5] = rst205.
- `grant` out 6: one-hot, one-`clk` pulse on the cycle a request is served. Same bit order as `pending`.

## Operation

- **Sampling**
  - On each `tick20`, the current levels of all six buttons are registered as `prev`.
  - Rising edge = current high and `prev` low. An edge sets the matching `pending` bit.
  - An edge on a bit that is already pending is dropped. There is no press counting.
- **Serving**
  - On each `tick20`, at most one request is served. Only requests pending *before* this tick are eligible; edges detected on the same tick are not.
  - Priority: rst10 > rst205 > add550 > add200 > add180 > add10.
  - The served bit clears; the matching `grant` pulses.
- **FSM states:** EMPTY, RUN, HOLD10, HOLD205.
  - **EMPTY** (`time_remain` = 0).
    - Served add → `time_remain` = value; go to RUN.
    - Served preset → load the preset; go to HOLDx.
    - `tick1` has no effect.
  - **RUN**
    - Served add → t = min(t + value, 9999).
    - `tick1` → t − 1. If the result is 0, go to EMPTY.
    - Served preset → load the preset; go to HOLDx.
  - **HOLD10 / HOLD205**
    - `time_remain` is pinned at 10 / 205. Countdown is suspended.
    - Add requests stay pending and are not granted; `grant` stays 0.
    - Leave on the first `tick20` where the owning button samples low: go to RUN. The next `tick20` resumes serving.
    - An edge on the other preset button sets its pending bit; it is served after release.
- **Arithmetic**
  - Sums are computed 15 bits wide, then saturated to 9999.
  - When add and decrement coincide in RUN: next = min(t + value, 9999) − 1.
  - From EMPTY, a coincident `tick1` is ignored: next = value.
  - A preset load always takes precedence over a coincident decrement.
- **Both presets pressed on the same tick:** both bits are set; rst10 is served first. rst205 is granted after HOLD10 is released and then loads 205.

## Timing

- **Reset**
  - `time_remain` = 0, state EMPTY, `expired` = 1, `holding` = 0, `pending` = 0, `grant` = 0, `prev` = 0.
  - A button already held when `reset` deasserts registers as a press on the first `tick20`.
  - `reset` has priority over ticks in the same cycle.
  - Asserting `reset` mid-hold or mid-count discards all pending requests.
- **Latency**
  - Edge sampled at `tick20` slot N → `pending` set after that edge.
  - The request is served at slot N+1, if it has top priority. `time_remain` and state update on that `clk` edge; `grant` is high during the following cycle.
- `expired` and `holding` are decoded from registered state, with no extra delay.
- Outputs change only on `tick20`, `tick1` or `reset` cycles. `grant` returns to 0 after one `clk`.

## Test plan

- **Reset and first add.** Assert `reset` with `add_btn` = 0001 held, then release → `time_remain` 0 and `expired` 1. `pending[0]` sets at the first `tick20`. At the second `tick20`, `time_remain` = 10, `expired` = 0, `grant` = 000001.
- **Priority.** Press +550 and +10 in the same slot from t = 100 → next slot t = 650, then t = 660. No `tick1` is active.
- **Saturation and coincidence.** t = 9990, +550 on a cycle with both `tick20` and `tick1` → t = 9998. A further +10 without `tick1` → 9999.
- **Countdown to expiry.** t = 2, two `tick1` → 1, then 0 with `expired` = 1. A third `tick1` keeps 0.
- **Hold.**
  - With t = 500, press and hold rst205 → t = 205, `holding` = 1.
  - 3× `tick1` and a +180 press → t stays 205, `pending[1]` = 1.
  - Release → RUN on that `tick20`; next `tick20` t = 385.
- **Both presets, then reset mid-hold.**
  - Press rst10 and rst205 together → HOLD10, t = 10, `pending[5]` = 1.
  - Release → after the next `tick20`, t = 205 in HOLD205.
  - Assert `reset` during the hold → t = 0, `pending` = 0, EMPTY.
